// File: rtl/pool_pkg.sv
// pool_pkg: shared constants and types for the max-pooling input streamer.
//   M, P, DW     : default map side, pooling window side, pixel width
//   PIX_PER_MAP  : pixels in one M x M feature map
//   stream_state_t : streamer control states (IDLE, RUN, DRAIN)
package pool_pkg;

  localparam int M  = 26;
  localparam int P  = 2;
  localparam int DW = 16;

  localparam int PIX_PER_MAP = M * M;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stream_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO that absorbs the buffer's 1-cycle read latency.
// An entry being written while the FIFO is empty is visible on rd_data in the
// same cycle, so the first pixel of a stream costs no extra cycle.
// When empty and not being written, rd_data repeats the last written entry.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wr_data    : write strobe and data
//   rd_en             : pop the head (legal when count != 0 or wr_en = 1)
//   rd_data           : head of the FIFO
//   count             : number of stored entries (0..2)
module stream_skid_fifo
  import pool_pkg::*;
#(
  parameter int DW = pool_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic [1:0]    wr_ptr_q;
  logic [1:0]    rd_ptr_q;

  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    rd_data = mem_q[rd_ptr_q[0]];
    if (count == 2'd0) begin
      rd_data = wr_en ? wr_data : mem_q[~rd_ptr_q[0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      // A bypassed entry is still written so the pointers stay balanced.
      if (wr_en) begin
        mem_q[wr_ptr_q[0]] <= wr_data;
        wr_ptr_q           <= wr_ptr_q + 2'd1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/pool_input_streamer.sv
// pool_input_streamer: reads NMAP row-major M x M feature maps from a
// synchronous single-port buffer and presents them one pixel per cycle (ce)
// to the pooling datapath, honouring a registered downstream stall.
// Optional feature: define POOL_STREAM_PERF_EN to add the stall_cycles counter.
// Ports:
//   clk, master_rst      : clock, asynchronous active-high reset
//   start                : one-cycle job request (accepted only when idle)
//   stall                : downstream hold
//   mem_en, mem_addr     : buffer read request
//   mem_rdata            : buffer read data, valid one cycle after mem_en
//   ce, pix_data         : pixel valid and value
//   pix_row, pix_col     : coordinates of the presented pixel
//   band_end             : last pixel of a P-row band
//   map_done             : pulse the cycle after the last pixel of each map
//   busy                 : job in progress
//   stall_cycles         : stalled cycles with data waiting (POOL_STREAM_PERF_EN)
module pool_input_streamer
  import pool_pkg::*;
#(
  parameter int M    = pool_pkg::M,
  parameter int P    = pool_pkg::P,
  parameter int NMAP = 1,
  parameter int DW   = pool_pkg::DW,
  parameter int AW   = 16
) (
  input  logic                          clk,
  input  logic                          master_rst,
  input  logic                          start,
  input  logic                          stall,
  output logic                          mem_en,
  output logic [AW-1:0]                 mem_addr,
  input  logic [DW-1:0]                 mem_rdata,
  output logic                          ce,
  output logic [DW-1:0]                 pix_data,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] pix_row,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] pix_col,
  output logic                          band_end,
  output logic                          map_done,
  output logic                          busy
`ifdef POOL_STREAM_PERF_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int CW    = (M > 1) ? $clog2(M) : 1;
  localparam int MW    = (NMAP > 1) ? $clog2(NMAP) : 1;
  localparam int TOTAL = NMAP * M * M;

  stream_state_t state_q;
  logic [AW-1:0] addr_q;
  logic          inflight_q;
  logic [CW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [MW-1:0] map_q;
  logic          map_done_q;

  logic [1:0]    fifo_count;
  logic [DW-1:0] fifo_head;
  logic          avail;
  logic [2:0]    occ;
  logic          last_col, last_row, last_map, last_read, last_pix;

  stream_skid_fifo #(.DW(DW)) u_fifo (
    .clk     (clk),
    .rst     (master_rst),
    .wr_en   (inflight_q),
    .wr_data (mem_rdata),
    .rd_en   (ce),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  // Data arriving this cycle counts as available: it bypasses an empty FIFO.
  assign avail = (fifo_count != 2'd0) || inflight_q;
  assign ce    = avail && !stall;

  // Occupancy after this edge must stay below 2 before another read goes out.
  assign occ    = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign mem_en = (state_q == RUN) && ((occ - {2'b00, ce}) < 3'd2);

  assign last_col  = (col_q == CW'(M - 1));
  assign last_row  = (row_q == CW'(M - 1));
  assign last_map  = (map_q == MW'(NMAP - 1));
  assign last_read = (addr_q == AW'(TOTAL - 1));
  assign last_pix  = ce && last_col && last_row && last_map;

  assign mem_addr = addr_q;
  assign pix_data = fifo_head;
  assign pix_row  = row_q;
  assign pix_col  = col_q;
  assign band_end = ce && last_col && ((int'(row_q) % P) == (P - 1));
  assign map_done = map_done_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      map_q      <= '0;
      map_done_q <= 1'b0;
    end else begin
      inflight_q <= mem_en;
      map_done_q <= ce && last_col && last_row;

      if (ce) begin
        if (last_col) begin
          col_q <= '0;
          if (last_row) begin
            row_q <= '0;
            map_q <= last_map ? '0 : map_q + MW'(1);
          end else begin
            row_q <= row_q + CW'(1);
          end
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            map_q   <= '0;
          end
        end
        RUN: begin
          if (mem_en) begin
            if (last_read) state_q <= DRAIN;
            else           addr_q  <= addr_q + AW'(1);
          end
        end
        DRAIN: begin
          if (last_pix) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef POOL_STREAM_PERF_EN
  logic [31:0] stall_cycles_q;

  assign stall_cycles = stall_cycles_q;

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      stall_cycles_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_cycles_q <= '0;
    end else if (busy && avail && stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end
`else
  // No stall counter in this build; streaming behaviour is unchanged.
`endif

endmodule

// File: doc/pool_input_streamer.md
# pool_input_streamer

Feature-map source for the max-pooling datapath. On a start pulse it reads NMAP feature maps of M×M pixels, in row-major order, from a synchronous single-port buffer. It then presents them one pixel per cycle with a `ce` qualifier to the pooling control/datapath pair, which consumes raster rows and forms P×P neighbourhoods. It honours a downstream `stall`, absorbs the buffer's 1-cycle read latency in a 2-entry skid FIFO, and flags map and job completion.

## Interface
- `M`, 26: feature-map side length in pixels; M mod P = 0.
- `P`, 2: pooling window side; used only for the `band_end` flag.
- `NMAP`, 1: number of maps streamed per job.
- `DW`, 16: pixel width.
- `AW`, 16: buffer address width; NMAP·M·M ≤ 2^AW.

- `clk`  in  1: clock; all state changes on the rising edge.
- `master_rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: one-cycle job request; honoured only in IDLE.
- `stall`  in  1: downstream hold; while high, no pixel is presented.
- `mem_en`  out  1: buffer read enable.
- `mem_addr`  out  AW: buffer read address.
- `mem_rdata`  in  DW: read data, valid exactly 1 cycle after `mem_en`.
- `ce`  out  1: pixel valid; the pixel counts as consumed on any cycle `ce`=1.
- `pix_data`  out  DW: pixel value.
- `pix_row`, `pix_col`  out  clog2(M): coordinates of the presented pixel.
- `band_end`  out  1: with `ce`, marks the last pixel of a P-row band.
- `map_done`  out  1: one-cycle pulse the cycle after the last pixel of each map.
- `busy`  out  1: high in every state except IDLE.
- `stall_cycles`  out  32: present only with `POOL_STREAM_PERF_EN`.

## Operation
- States:
  - IDLE: waits for `start`. `start` → RUN.
  - RUN: issues reads. When the last read is issued → DRAIN.
  - DRAIN: no reads are issued. When the last pixel is consumed → IDLE.
- Reads are linear. The read address counter starts at 0 and increments by 1 per read, up to NMAP·M·M−1. Map k occupies addresses k·M·M through (k+1)·M·M−1.
- Read issue rule in RUN: `mem_en`=1 iff (fifo_count + inflight − pop) < 2. Here pop = `ce` this cycle, and inflight = `mem_en` on the previous cycle. This rule guarantees FIFO overflow is impossible.
- Returned data is written into the FIFO on the cycle after `mem_en`.
- `ce` = FIFO not empty AND NOT `stall`. This is combinational in `stall`; the source of `stall` must drive it from a register.
- `pix_data` = FIFO head. It is held stable while `ce`=0.
- The output coordinate counters advance on `ce`:
  - `pix_col` wraps from M−1 to 0, and `pix_row` increments on that wrap.
  - `pix_row` wraps from M−1 to 0 and increments the map index.
- `band_end` = `ce` AND `pix_col`=M−1 AND (`pix_row` mod P)=P−1.
- `start` while `busy` is ignored. `stall` in IDLE has no effect.
- Reset values:
  - State IDLE.
  - `ce`, `mem_en`, `map_done`, `busy` = 0.
  - `mem_addr`, `pix_row`, `pix_col`, map index, FIFO pointers, `stall_cycles` = 0.
  - `pix_data` = 0.
- Reset asserted mid-job discards the FIFO and any in-flight read. The first job after reset release starts at address 0.

## Timing
- Start latency: `start` at cycle t gives `mem_en`=1 and `mem_addr`=0 at t+1, and `ce`=1 with pixel 0 at t+2.
- Unstalled throughput: 1 pixel per cycle. `ce` is high on NMAP·M·M consecutive cycles.
- Stall:
  - `ce` drops in the same cycle `stall` rises.
  - Resume is zero-bubble: the first cycle with `stall`=0 presents the held pixel.
  - A 1-cycle stall delays the stream by exactly 1 cycle.
- `map_done` pulses on the cycle after the cycle in which `ce` carries pixel (M−1, M−1) of each map.
- On the last map, `busy` falls on that same cycle, i.e. `busy`=0 and `map_done`=1 together.
- A `start` on the cycle `busy` falls is accepted.

## Configuration
- `POOL_STREAM_PERF_EN` defined:
  - Adds the `stall_cycles` port and counter.
  - The counter increments on every cycle with `busy`=1 AND FIFO not empty AND `stall`=1.
  - It saturates at 2^32−1 and clears on `start` acceptance and on reset.
- `POOL_STREAM_PERF_EN` undefined: no port, no counter logic, and identical streaming behaviour.

## Structure
- Shared package `pool_pkg` holds:
  - Default constants M, P, DW.
  - The state typedef `stream_state_t` with values IDLE, RUN, DRAIN.
  - Helper localparam PIX_PER_MAP = M·M.
- Sub-module `stream_skid_fifo`:
  - Parameterised 2-entry FIFO with `wr_en`, `wr_data`, `rd_en`, `rd_data`, `count`.
  - Uses the same asynchronous active-high reset.

## Test plan
- **Basic job:** M=4, P=2, NMAP=1, memory[i]=i, no stall, `start` at cycle 0. Required response:
  - `ce` is high for cycles 2–17 with `pix_data` 0..15.
  - `band_end` is high at pixels 7 and 15.
  - `map_done` and `busy`=0 occur at cycle 18.
- **Stall pattern:** same setup with `stall` high on cycles 5–7, stimulus otherwise unchanged. Required response:
  - `ce`=0 on cycles 5–7 with `pix_data` held at 3.
  - Pixel 3 is presented on cycle 8, and pixel 15 on cycle 20.
  - No pixel is lost or duplicated.
- **Multi-map:** NMAP=2, M=4, no stall. Required response:
  - 32 consecutive `ce` cycles.
  - `map_done` pulses at cycles 18 and 34.
  - `mem_addr` reaches 31.
  - `pix_row` and `pix_col` wrap to 0 at pixel 16.
- **Busy/start overlap:** `start` re-pulsed at cycle 6 of a running job, and again on the cycle `busy` falls. Required response:
  - The first re-pulse is ignored.
  - The second starts a new job, with `ce` appearing 2 cycles later at address 0.
- **Reset mid-job:** `master_rst` asserted asynchronously mid-job at pixel 9 with the FIFO full. Required response:
  - All outputs are at reset values immediately.
  - After release plus `start`, the stream restarts at pixel 0.
- **Perf counter:** with `POOL_STREAM_PERF_EN`, the stall scenario reports `stall_cycles`=3, and 0 after the next `start`.
